// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, execute,
// memory and writeback steps and drives datapath selects/enables.
// Ports: clk, rst (sync, active-high); opcode, mem_ready in;
//   mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, branch,
//   alu_src_a, alu_src_b, alu_op, result_src, illegal, state out.
// Build option: define ILLEGAL_TRAP_EN to trap unlisted opcodes in TRAP.
// state codes follow declaration order: FETCH=0 ... TRAP=15.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD,
        MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR,
        JALRWB, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;
    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;

    state_t cur, nxt;

    always_ff @(posedge clk) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    // Debug view reads FETCH throughout reset, even on the first
    // reset cycle before the register has been cleared.
    assign state = rst ? 4'(FETCH) : 4'(cur);

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = A_PC;
        alu_src_b  = B_RS2;
        alu_op     = 2'b00;
        result_src = 2'b00;
        illegal    = 1'b0;
        unique case (cur)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = B_FOUR;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
                case (opcode)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011:             nxt = EXECR;
                    7'b0010011:             nxt = EXECI;
                    7'b1100011:             nxt = BRANCH;
                    7'b1101111:             nxt = JAL;
                    7'b1100111:             nxt = JALR;
                    7'b0110111:             nxt = LUI;
                    7'b0010111:             nxt = AUIPC;
                    7'b0001111, 7'b1110011: nxt = FETCH;
`ifdef ILLEGAL_TRAP_EN
                    default:                nxt = TRAP;
`else
                    default:                nxt = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                nxt = (opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) nxt = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                nxt        = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) nxt = FETCH;
            end
            EXECR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_RS2;
                alu_op    = 2'b11;
                nxt       = ALUWB;
            end
            EXECI: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                alu_op    = 2'b10;
                nxt       = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                alu_src_a = A_RS1;
                alu_src_b = B_RS2;
                alu_op    = 2'b01;
                branch    = 1'b1;
                nxt       = FETCH;
            end
            JAL: begin
                pc_write  = 1'b1;
                alu_src_a = A_OLDPC;
                alu_src_b = B_FOUR;
                nxt       = ALUWB;
            end
            JALR: begin
                pc_write   = 1'b1;
                result_src = 2'b10;
                alu_src_a  = A_RS1;
                alu_src_b  = B_IMM;
                nxt        = JALRWB;
            end
            JALRWB: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                alu_src_a  = A_OLDPC;
                alu_src_b  = B_FOUR;
                nxt        = FETCH;
            end
            LUI: begin
                alu_src_a = A_ZERO;
                alu_src_b = B_IMM;
                nxt       = ALUWB;
            end
            AUIPC: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
                nxt       = ALUWB;
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
                nxt     = TRAP;
`else
                nxt     = FETCH;
`endif
            end
        endcase
        // Reset silences every datapath control, including mem_req.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_src   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            branch     = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: instruction-level reference model
// feeding a per-cycle scoreboard checked by a negedge monitor.
module tb_multicycle_control;

    logic       clk, rst, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, addr_src, ir_write, pc_write;
    logic       reg_write, branch, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
        .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .branch(branch),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src),
        .illegal(illegal), .state(state)
    );

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2;
    localparam int P_MEMREAD = 3, P_MEMWB = 4, P_MEMWRITE = 5;
    localparam int P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8;
    localparam int P_BRANCH = 9, P_JAL = 10, P_JALR = 11;
    localparam int P_JALRWB = 12, P_LUI = 13, P_AUIPC = 14;
    localparam int P_TRAP = 15;

    logic [19:0] sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] exp_out(int ph, logic rdy);
        logic req, we, as, irw, pcw, rw, br, ill;
        logic [1:0] a, b, op, rs;
        {req, we, as, irw, pcw, rw, br, ill} = '0;
        {a, b, op, rs} = '0;
        case (ph)
            P_FETCH:    begin req = 1; b = 2; rs = 2;
                              irw = rdy; pcw = rdy; end
            P_DECODE:   begin a = 1; b = 1; end
            P_MEMADR:   begin a = 2; b = 1; end
            P_MEMREAD:  begin req = 1; as = 1; end
            P_MEMWB:    begin rw = 1; rs = 1; end
            P_MEMWRITE: begin req = 1; we = 1; as = 1; end
            P_EXECR:    begin a = 2; b = 0; op = 3; end
            P_EXECI:    begin a = 2; b = 1; op = 2; end
            P_ALUWB:    begin rw = 1; rs = 0; end
            P_BRANCH:   begin a = 2; op = 1; br = 1; end
            P_JAL:      begin pcw = 1; a = 1; b = 2; end
            P_JALR:     begin pcw = 1; rs = 2; a = 2; b = 1; end
            P_JALRWB:   begin rw = 1; rs = 2; a = 1; b = 2; end
            P_LUI:      begin a = 3; b = 1; end
            P_AUIPC:    begin a = 1; b = 1; end
            P_TRAP:     begin ill = 1; end
            default:    ;
        endcase
        return {req, we, as, irw, pcw, rw, br,
                a, b, op, rs, ill, 4'(ph)};
    endfunction

    task automatic step(int ph, logic rdy, logic [6:0] opc, logic r);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        opcode    = opc;
        sb.push_back(r ? 20'h0 : exp_out(ph, rdy));
    endtask

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    task automatic run_instr(logic [6:0] op, int stall);
        int seq[$];
        int n;
        seq.push_back(P_FETCH);
        seq.push_back(P_DECODE);
        case (op)
            7'b0000011: begin seq.push_back(P_MEMADR);
                        seq.push_back(P_MEMREAD);
                        seq.push_back(P_MEMWB); end
            7'b0100011: begin seq.push_back(P_MEMADR);
                        seq.push_back(P_MEMWRITE); end
            7'b0110011: begin seq.push_back(P_EXECR);
                        seq.push_back(P_ALUWB); end
            7'b0010011: begin seq.push_back(P_EXECI);
                        seq.push_back(P_ALUWB); end
            7'b1100011: seq.push_back(P_BRANCH);
            7'b1101111: begin seq.push_back(P_JAL);
                        seq.push_back(P_ALUWB); end
            7'b1100111: begin seq.push_back(P_JALR);
                        seq.push_back(P_JALRWB); end
            7'b0110111: begin seq.push_back(P_LUI);
                        seq.push_back(P_ALUWB); end
            7'b0010111: begin seq.push_back(P_AUIPC);
                        seq.push_back(P_ALUWB); end
            7'b0001111, 7'b1110011: ;
            default: begin
`ifdef ILLEGAL_TRAP_EN
                seq.push_back(P_TRAP);
`endif
            end
        endcase
        foreach (seq[i]) begin
            int ph;
            ph = seq[i];
            if (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE) begin
                n = (stall < 0 || ph == P_FETCH) ?
                    int'($urandom_range(0, 3)) : stall;
                repeat (n) step(ph, 1'b0, junk(), 1'b0);
                step(ph, 1'b1, junk(), 1'b0);
            end else if (ph == P_DECODE || ph == P_MEMADR) begin
                step(ph, 1'($urandom), op, 1'b0);
            end else if (ph == P_TRAP) begin
                repeat (12) step(P_TRAP, 1'($urandom), junk(), 1'b0);
                step(P_FETCH, 1'($urandom), junk(), 1'b1);
            end else begin
                step(ph, 1'($urandom), junk(), 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] act, exp_v;
        cyc++;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act = {mem_req, mem_we, addr_src, ir_write, pc_write,
                   reg_write, branch, alu_src_a, alu_src_b, alu_op,
                   result_src, illegal, state};
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL ctrl cyc=%0d got=%05h exp=%05h",
                         cyc, act, exp_v);
            end
        end
    end

    logic [6:0] ops[14] = '{
        7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
        7'b0010111, 7'b0001111, 7'b1110011,
        7'b0000000, 7'b1111111, 7'b0101010
    };

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = '0;
        repeat (2) step(P_FETCH, 1'($urandom), junk(), 1'b1);

        run_instr(7'b0110011, 0);
        run_instr(7'b0000011, 3);
        run_instr(7'b0100011, 2);
        run_instr(7'b1100011, 0);
        run_instr(7'b1100111, 0);
        run_instr(7'b1101111, 0);
        run_instr(7'b0001111, 0);
        run_instr(7'b1110011, 0);
        run_instr(7'b0000000, 0);

        step(P_FETCH, 1'b1, junk(), 1'b0);
        step(P_DECODE, 1'b0, 7'b0000011, 1'b0);
        step(P_MEMADR, 1'b1, 7'b0000011, 1'b0);
        step(P_MEMREAD, 1'b0, junk(), 1'b0);
        step(P_MEMREAD, 1'b0, junk(), 1'b0);
        step(P_FETCH, 1'b0, junk(), 1'b1);
        step(P_FETCH, 1'b1, junk(), 1'b1);
        @(negedge clk);
        tests++;
        if (state !== 4'd0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rst state=%0d mem_req=%b", state, mem_req);
        end
        run_instr(7'b0110111, 1);

        for (int k = 0; k < 300; k++)
            run_instr(ops[$urandom_range(0, 13)], -1);

        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard left=%0d", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
